// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Responder end of the processor data-memory interface. Word and sub-word
//   reads are combinational; word writes commit on the rising clock edge.
//   256-bit block reads/writes go through a three-state FSM (IDLE/WAIT/DONE)
//   that holds Busy_OUT for LATENCY cycles and then pulses Valid_OUT once.
//   Byte order is big-endian: byte at addr[1:0]=0 lives in bits [31:24].
//
// Parameters
//   MEM_WORDS  storage depth in 32-bit words (power of two, >= 8)
//   LATENCY    block-access busy cycles (1..15)
//
// Ports
//   CLOCK, RESET          rising-edge clock, asynchronous active-high reset
//   DataAddress_IN[31:0]  byte address (word and block accesses)
//   Data_IN[31:0]         write data, right-justified
//   DataSize_IN[1:0]      bytes accessed: 1,2,3; 0 means 4
//   MemRead_IN            word/sub-word read
//   MemWrite_IN           word/sub-word write
//   MemBlockRead_IN       block read request
//   MemBlockWrite_IN      block write request
//   DataBlock_IN[255:0]   block write data, word 0 at [255:224]
//   Data_OUT[31:0]        read data, right-justified, zero-extended
//   DataBlock_OUT[255:0]  block read data, word 0 at [255:224]
//   Busy_OUT              block access in progress
//   Valid_OUT             one-cycle block completion pulse
//
// Optional feature (macro RESPONDER_STATS_EN)
//   Adds BlockReadCount_OUT[15:0] / BlockWriteCount_OUT[15:0], saturating
//   counters of completed block reads/writes, cleared by RESET.
// -----------------------------------------------------------------------------
module data_memory_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 4
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic [31:0]  DataAddress_IN,
   input  logic [31:0]  Data_IN,
   input  logic [1:0]   DataSize_IN,
   input  logic         MemRead_IN,
   input  logic         MemWrite_IN,
   input  logic         MemBlockRead_IN,
   input  logic         MemBlockWrite_IN,
   input  logic [255:0] DataBlock_IN,
   output logic [31:0]  Data_OUT,
   output logic [255:0] DataBlock_OUT,
   output logic         Busy_OUT,
   output logic         Valid_OUT
`ifdef RESPONDER_STATS_EN
   ,
   output logic [15:0]  BlockReadCount_OUT,
   output logic [15:0]  BlockWriteCount_OUT
`endif
);

   localparam int unsigned IDXW = $clog2(MEM_WORDS);
   localparam int unsigned BLKW = IDXW - 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [BLKW-1:0]   blk_q, blk_d;
   logic              wr_q, wr_d;
   logic [255:0]      wdat_q, wdat_d;
   logic [255:0]      rblk_q, rblk_d;
   logic              commit;

   logic [31:0]       mem_q [MEM_WORDS];

   // ---------------- word access datapath ----------------
   logic [IDXW-1:0]   widx;
   logic [1:0]        off;
   logic [2:0]        nreq, navail, neff, rsh, lsh;
   logic [31:0]       rd_word, wword, wmask;
   logic              unused_addr;

   assign widx        = DataAddress_IN[IDXW+1:2];
   assign off         = DataAddress_IN[1:0];
   assign nreq        = (DataSize_IN == 2'd0) ? 3'd4 : {1'b0, DataSize_IN};
   assign navail      = 3'd4 - {1'b0, off};
   assign neff        = (nreq < navail) ? nreq : navail;
   assign rsh         = 3'd4 - neff;
   assign lsh         = 3'd4 - nreq;
   assign rd_word     = mem_q[widx];
   assign unused_addr = ^DataAddress_IN[31:IDXW+2];

   // Read: shift the addressed byte to the top, then right-justify only the
   // bytes that exist inside the word, so bytes past the boundary read as 0.
   always_comb begin
      Data_OUT = '0;
      if (MemRead_IN) begin
         Data_OUT = (rd_word << {off, 3'b000}) >> {rsh, 3'b000};
      end
   end

   // Write: left-justify the n valid bytes, then slide them to the addressed
   // lane; anything pushed past lane 3 falls off and is dropped.
   assign wword = (Data_IN << {lsh, 3'b000}) >> {off, 3'b000};
   assign wmask = (32'hFFFF_FFFF << {lsh, 3'b000}) >> {off, 3'b000};

   // Block commit is sequenced after the word write so it wins on overlap.
   always_ff @(posedge CLOCK) begin
      if (MemWrite_IN) begin
         mem_q[widx] <= (mem_q[widx] & ~wmask) | (wword & wmask);
      end
      if (commit) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem_q[{blk_q, 3'(i)}] <= wdat_q[255-32*i -: 32];
         end
      end
   end

   // ---------------- block FSM ----------------
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         wr_q    <= 1'b0;
         wdat_q  <= '0;
         rblk_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         wr_q    <= wr_d;
         wdat_q  <= wdat_d;
         rblk_q  <= rblk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      wr_d    = wr_q;
      wdat_d  = wdat_q;
      rblk_d  = rblk_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemBlockRead_IN || MemBlockWrite_IN) begin
               state_d = S_WAIT;
               cnt_d   = 4'(LATENCY - 1);
               blk_d   = DataAddress_IN[IDXW+1:5];
               wr_d    = MemBlockWrite_IN;
               if (MemBlockWrite_IN) begin
                  wdat_d = DataBlock_IN;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               if (wr_q) begin
                  commit = 1'b1;
               end else begin
                  for (int unsigned i = 0; i < 8; i++) begin
                     rblk_d[255-32*i -: 32] = mem_q[{blk_q, 3'(i)}];
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign Busy_OUT      = (state_q == S_WAIT);
   assign Valid_OUT     = (state_q == S_DONE);
   assign DataBlock_OUT = rblk_q;

`ifdef RESPONDER_STATS_EN
   logic [15:0] rcnt_q, wcnt_q;
   logic        finish;

   assign finish = (state_q == S_WAIT) && (cnt_q == 4'd0);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         rcnt_q <= '0;
         wcnt_q <= '0;
      end else if (finish) begin
         if (!wr_q && (rcnt_q != 16'hFFFF)) rcnt_q <= rcnt_q + 16'd1;
         if ( wr_q && (wcnt_q != 16'hFFFF)) wcnt_q <= wcnt_q + 16'd1;
      end
   end

   assign BlockReadCount_OUT  = rcnt_q;
   assign BlockWriteCount_OUT = wcnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//   Directed bench for data_memory_responder (MEM_WORDS=1024, LATENCY=4).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int unsigned LAT = 4;

   logic         CLOCK;
   logic         RESET;
   logic [31:0]  DataAddress_IN;
   logic [31:0]  Data_IN;
   logic [1:0]   DataSize_IN;
   logic         MemRead_IN;
   logic         MemWrite_IN;
   logic         MemBlockRead_IN;
   logic         MemBlockWrite_IN;
   logic [255:0] DataBlock_IN;
   logic [31:0]  Data_OUT;
   logic [255:0] DataBlock_OUT;
   logic         Busy_OUT;
   logic         Valid_OUT;
`ifdef RESPONDER_STATS_EN
   logic [15:0]  BlockReadCount_OUT;
   logic [15:0]  BlockWriteCount_OUT;
`endif

   int unsigned passed = 0;
   int unsigned total  = 0;

   localparam logic [255:0] BV  = 256'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777;
   localparam logic [255:0] A5V = {8{32'hA5A5A5A5}};

   data_memory_responder #(
      .MEM_WORDS (1024),
      .LATENCY   (LAT)
   ) dut (
      .CLOCK            (CLOCK),
      .RESET            (RESET),
      .DataAddress_IN   (DataAddress_IN),
      .Data_IN          (Data_IN),
      .DataSize_IN      (DataSize_IN),
      .MemRead_IN       (MemRead_IN),
      .MemWrite_IN      (MemWrite_IN),
      .MemBlockRead_IN  (MemBlockRead_IN),
      .MemBlockWrite_IN (MemBlockWrite_IN),
      .DataBlock_IN     (DataBlock_IN),
      .Data_OUT         (Data_OUT),
      .DataBlock_OUT    (DataBlock_OUT),
      .Busy_OUT         (Busy_OUT),
      .Valid_OUT        (Valid_OUT)
`ifdef RESPONDER_STATS_EN
      ,
      .BlockReadCount_OUT  (BlockReadCount_OUT),
      .BlockWriteCount_OUT (BlockWriteCount_OUT)
`endif
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      @(negedge CLOCK);
      DataAddress_IN = a;
      Data_IN        = d;
      DataSize_IN    = s;
      MemRead_IN     = 1'b0;
      MemWrite_IN    = 1'b1;
      @(negedge CLOCK);
      MemWrite_IN    = 1'b0;
   endtask

   task automatic rd_word(input logic [31:0] a, input logic [1:0] s, input logic [31:0] exp,
                          input string tag);
      @(negedge CLOCK);
      DataAddress_IN = a;
      DataSize_IN    = s;
      MemRead_IN     = 1'b1;
      #1;
      chk(tag, 256'(Data_OUT), 256'(exp));
      MemRead_IN     = 1'b0;
   endtask

   // Issues one block request, optionally injects a word write in the second
   // WAIT cycle, checks Busy for LAT cycles and leaves the bench in the Valid cycle.
   task automatic blk(input logic [31:0] a, input logic rd, input logic wr, input logic [255:0] d,
                      input logic ww, input logic [31:0] wa, input logic [31:0] wd,
                      input string tag);
      @(negedge CLOCK);
      DataAddress_IN   = a;
      MemBlockRead_IN  = rd;
      MemBlockWrite_IN = wr;
      DataBlock_IN     = d;
      for (int c = 0; c < LAT; c++) begin
         @(negedge CLOCK);
         MemBlockRead_IN  = 1'b0;
         MemBlockWrite_IN = 1'b0;
         MemWrite_IN      = ww && (c == 1);
         DataAddress_IN   = wa;
         Data_IN          = wd;
         DataSize_IN      = 2'd0;
         #1;
         chk({tag, "_busy"},    256'(Busy_OUT),  256'(1));
         chk({tag, "_novalid"}, 256'(Valid_OUT), 256'(0));
      end
      @(negedge CLOCK);
      MemWrite_IN = 1'b0;
      #1;
      chk({tag, "_done_busy"}, 256'(Busy_OUT),  256'(0));
      chk({tag, "_valid"},     256'(Valid_OUT), 256'(1));
   endtask

   initial begin
      RESET            = 1'b1;
      DataAddress_IN   = '0;
      Data_IN          = '0;
      DataSize_IN      = '0;
      MemRead_IN       = 1'b0;
      MemWrite_IN      = 1'b0;
      MemBlockRead_IN  = 1'b0;
      MemBlockWrite_IN = 1'b0;
      DataBlock_IN     = '0;
      #2;
      chk("rst_busy",  256'(Busy_OUT),  256'(0));
      chk("rst_valid", 256'(Valid_OUT), 256'(0));
      chk("rst_dblk",  DataBlock_OUT,   256'(0));
      @(negedge CLOCK);
      @(negedge CLOCK);
      RESET = 1'b0;

      // full word write and same-cycle read; read disabled gives zero
      wr_word(32'h100, 32'hDEADBEEF, 2'd0);
      rd_word(32'h100, 2'd0, 32'hDEADBEEF, "word_rd");
      #1;
      chk("rd_disabled", 256'(Data_OUT), 256'(0));

      // simultaneous read+write returns pre-write byte
      @(negedge CLOCK);
      DataAddress_IN = 32'h101;
      Data_IN        = 32'h000000AB;
      DataSize_IN    = 2'd1;
      MemRead_IN     = 1'b1;
      MemWrite_IN    = 1'b1;
      #1;
      chk("rw_same_cycle", 256'(Data_OUT), 256'(32'h000000AD));
      @(negedge CLOCK);
      MemWrite_IN = 1'b0;
      MemRead_IN  = 1'b0;
      rd_word(32'h100,  2'd0, 32'hDEABBEEF, "byte_wr");
      rd_word(32'h102,  2'd2, 32'h0000BEEF, "half_rd");
      rd_word(32'h103,  2'd2, 32'h000000EF, "half_boundary");
      rd_word(32'h1100, 2'd0, 32'hDEABBEEF, "addr_wrap");

      // writes crossing the word boundary drop the excess bytes
      wr_word(32'h104, 32'h00000000, 2'd0);
      wr_word(32'h107, 32'h00001234, 2'd2);
      rd_word(32'h104, 2'd0, 32'h00000012, "wr_boundary");
      wr_word(32'h108, 32'h00000000, 2'd0);
      wr_word(32'h108, 32'hFFABCDEF, 2'd3);
      rd_word(32'h108, 2'd0, 32'hABCDEF00, "wr_size3");

      // block read of 0x100 via a misaligned address
      blk(32'h104, 1'b1, 1'b0, '0, 1'b0, 32'h0, 32'h0, "blkrd100");
      chk("blkrd_w0", 256'(DataBlock_OUT[255:224]), 256'(32'hDEABBEEF));
      chk("blkrd_w1", 256'(DataBlock_OUT[223:192]), 256'(32'h00000012));
      chk("blkrd_w2", 256'(DataBlock_OUT[191:160]), 256'(32'hABCDEF00));
      @(negedge CLOCK);
      #1;
      chk("valid_one_cycle", 256'(Valid_OUT), 256'(0));

      // block write; a word write during WAIT is overwritten by the commit
      blk(32'h200, 1'b0, 1'b1, BV, 1'b1, 32'h204, 32'hFFFFFFFF, "blkwr200");
      chk("dblk_held", 256'(DataBlock_OUT[255:224]), 256'(32'hDEABBEEF));
      blk(32'h20C, 1'b1, 1'b0, '0, 1'b0, 32'h0, 32'h0, "blkrd20C");
      chk("blkrd_all", DataBlock_OUT, BV);
      rd_word(32'h214, 2'd0, 32'h55555555, "blk_word5");
      rd_word(32'h204, 2'd0, 32'h11111111, "blk_overrides_word");

      // reset during WAIT of a block write discards it
      wr_word(32'h300, 32'hCAFEF00D, 2'd0);
      @(negedge CLOCK);
      DataAddress_IN   = 32'h300;
      DataBlock_IN     = A5V;
      MemBlockWrite_IN = 1'b1;
      @(negedge CLOCK);
      MemBlockWrite_IN = 1'b0;
      #1;
      chk("rstwait_busy", 256'(Busy_OUT), 256'(1));
      @(negedge CLOCK);
      RESET = 1'b1;
      #1;
      chk("rst_mid_busy", 256'(Busy_OUT),  256'(0));
      chk("rst_mid_dblk", DataBlock_OUT,   256'(0));
`ifdef RESPONDER_STATS_EN
      chk("rst_mid_rcnt", 256'(BlockReadCount_OUT),  256'(0));
      chk("rst_mid_wcnt", 256'(BlockWriteCount_OUT), 256'(0));
`endif
      @(negedge CLOCK);
      RESET = 1'b0;
      for (int c = 0; c < LAT + 2; c++) @(negedge CLOCK);
      #1;
      chk("rst_no_valid", 256'(Valid_OUT), 256'(0));
      rd_word(32'h300, 2'd0, 32'hCAFEF00D, "rst_discard");

      // both requests asserted: treated as a write
      blk(32'h300, 1'b1, 1'b1, A5V, 1'b0, 32'h0, 32'h0, "blkboth");
      chk("both_no_rd", DataBlock_OUT, 256'(0));
      rd_word(32'h300, 2'd0, 32'hA5A5A5A5, "both_w0");
      rd_word(32'h31C, 2'd0, 32'hA5A5A5A5, "both_w7");

`ifdef RESPONDER_STATS_EN
      blk(32'h300, 1'b1, 1'b0, '0, 1'b0, 32'h0, 32'h0, "st_rd1");
      blk(32'h200, 1'b1, 1'b0, '0, 1'b0, 32'h0, 32'h0, "st_rd2");
      blk(32'h100, 1'b1, 1'b0, '0, 1'b0, 32'h0, 32'h0, "st_rd3");
      blk(32'h200, 1'b0, 1'b1, BV, 1'b0, 32'h0, 32'h0, "st_wr2");
      @(negedge CLOCK);
      #1;
      chk("stat_rcnt", 256'(BlockReadCount_OUT),  256'(3));
      chk("stat_wcnt", 256'(BlockWriteCount_OUT), 256'(2));
      RESET = 1'b1;
      #1;
      chk("stat_rcnt_rst", 256'(BlockReadCount_OUT),  256'(0));
      chk("stat_wcnt_rst", 256'(BlockWriteCount_OUT), 256'(0));
      @(negedge CLOCK);
      RESET = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
